frac_bin_to_bcd: RTL and testbench

FRAC_BIN_TO_BCD -- requirements
Module: frac_bin_to_bcd

---
 rtl/frac_bin_to_bcd_pkg.sv | 17 +
 rtl/frac_bin_to_bcd_add3.sv | 10 +
 rtl/frac_bin_to_bcd.sv | 91 +++++++++
 tb/tb_frac_bin_to_bcd.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/frac_bin_to_bcd_pkg.sv
// Shared defaults, FSM encoding and saturation constants
// for the fraction-to-BCD converter.
package frac_bin_to_bcd_pkg;

    localparam int W_IN_DEF  = 24;
    localparam int N_DIG_DEF = 7;

    localparam logic [3:0] BCD_NINE = 4'h9;
    localparam logic [4*N_DIG_DEF-1:0] BCD_SAT = {N_DIG_DEF{BCD_NINE}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/frac_bin_to_bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit >= 5
// so the following left shift carries into the next decade.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/frac_bin_to_bcd.sv
// Iterative binary-to-BCD converter for the fraction path,
// one input bit per cycle MSB first, with overflow saturation.
module frac_bin_to_bcd
    import frac_bin_to_bcd_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int N_DIG = N_DIG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W_IN-1:0]    frac_in,
    output logic               busy,
    output logic               done,
    output logic [4*N_DIG-1:0] bcd_out,
    output logic               ovf
);

    localparam int CW = $clog2(W_IN + 1);
    localparam int AW = 4 * (N_DIG + 1);
    localparam logic [4*N_DIG-1:0] SAT = {N_DIG{BCD_NINE}};

    state_t          state;
    state_t          state_nx;
    logic [W_IN-1:0] sr;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_fix;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            top_nz;

    // A start coinciding with the done pulse is not a new request
    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state == SHIFT);
    assign top_nz = |acc[AW-1 -: 4];

    for (genvar g = 0; g < N_DIG + 1; g++) begin : g_fix
        bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_fix[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr  <= frac_in;
                        acc <= '0;
                        cnt <= CW'(W_IN);
                    end
                end
                SHIFT: begin
                    {acc, sr} <= {acc_fix, sr} << 1;
                    cnt       <= cnt - 1'b1;
                end
                DONE: begin
                    ovf     <= top_nz;
                    bcd_out <= top_nz ? SAT : acc[4*N_DIG-1:0];
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frac_bin_to_bcd.sv
// Randomised self-checking bench for frac_bin_to_bcd against a
// decimal-digit reference model.
module tb_frac_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] frac_in = '0;
    logic        busy;
    logic        done;
    logic [27:0] bcd_out;
    logic        ovf;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int conv_cnt = 0;

    frac_bin_to_bcd dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .frac_in (frac_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_conv(input int unsigned v,
                                     output logic [27:0] bcd,
                                     output logic ov);
        int unsigned x;
        bcd = '0;
        if (v > 9999999) begin
            ov  = 1'b1;
            bcd = 28'h9999999;
        end else begin
            ov = 1'b0;
            x  = v;
            for (int i = 0; i < 7; i++) begin
                bcd[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
    endfunction

    task automatic check_nibbles();
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 7; i++)
            if (bcd_out[4*i +: 4] > 4'd9) ok = 1'b0;
        check("nibble", ok, 1);
    endtask

    // Starts in the current cycle (caller is at a negedge). With
    // hold set, start stays high with v2 until after the done pulse.
    task automatic do_conv(input int unsigned v,
                           input int unsigned v2,
                           input bit hold);
        logic [27:0] eb;
        logic        eo;
        int          lat;
        ref_conv(v, eb, eo);
        frac_in = 24'(v);
        start   = 1'b1;
        @(negedge clk);
        conv_cnt++;
        start   = hold;
        frac_in = hold ? 24'(v2) : 24'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            check("busy", busy, lat < 24);
            check("excl", busy & done, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 25);
        check("excl", busy & done, 0);
        check("bcd", bcd_out, eb);
        check("ovf", ovf, eo);
        check_nibbles();
        @(negedge clk);
        start = 1'b0;
        check("pulse", done, 0);
        check("idle", busy, 0);
        check("hold_bcd", bcd_out, eb);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);

        do_conv(5000000, 0, 0);
        do_conv(9999999, 0, 0);
        do_conv(0, 0, 0);
        do_conv(1, 0, 0);
        do_conv(16777215, 0, 0);
        do_conv(10000000, 0, 0);
        do_conv(19531, 39062, 1);
        do_conv(39062, 0, 0);

        frac_in = 24'd12345;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd", bcd_out, 0);
        check("abort_ovf", ovf, 0);
        repeat (30) @(negedge clk);
        check("abort_nodone", done_cnt, conv_cnt);
        do_conv(78125, 0, 0);

        for (int r = 0; r < 1000; r++)
            do_conv($urandom_range(9999999, 0), 0, 0);

        @(negedge clk);
        check("done_count", done_cnt, conv_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
